// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared widths, field offsets and state encoding for pipe_stage_skid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 8;

  // Payload layout, LSB first
  localparam int ALU_OUT_LSB    = 0;
  localparam int ALU_OUT_W      = 32;
  localparam int STORE_DATA_LSB = 32;
  localparam int STORE_DATA_W   = 32;
  localparam int RD_LSB         = 64;
  localparam int RD_W           = 5;
  localparam int PC_PLUS_4_LSB  = 69;
  localparam int PC_PLUS_4_W    = 32;

  // Control layout, LSB first
  localparam int REGWRITE_BIT   = 0;
  localparam int MEMWRITE_BIT   = 1;
  localparam int MEMREAD_BIT    = 2;
  localparam int WDSEL_LSB      = 3;
  localparam int WDSEL_W        = 2;
  localparam int DMTYPE_LSB     = 5;
  localparam int DMTYPE_W       = 3;

  // Occupancy state is the concatenation {main_v, skid_v}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
// ============================================================================
// Module : pipe_stage_skid_if
// Brief  : Upstream and downstream valid/ready channel of one pipeline stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_stage_skid_if #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8
);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;

  // The stage itself
  modport slave (
    input  i_valid, i_data, i_ctrl, i_ready,
    output o_ready, o_valid, o_data, o_ctrl
  );

  // Whatever surrounds the stage
  modport master (
    output i_valid, i_data, i_ctrl, i_ready,
    input  o_ready, o_valid, o_data, o_ctrl
  );

endinterface

`default_nettype wire

// File: rtl/pipe_entry.sv
// ============================================================================
// Module : pipe_entry
// Brief  : One valid + data + ctrl holding register with load enable and clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_entry #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_clr,
  input  wire logic              i_ld,
  input  wire logic              i_v,
  input  wire logic [DATA_W-1:0] i_d,
  input  wire logic [CTRL_W-1:0] i_c,
  output logic                   o_v,
  output logic      [DATA_W-1:0] o_d,
  output logic      [CTRL_W-1:0] o_c
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [CTRL_W-1:0] c_q, c_d;

  // Valid follows its next-state every cycle; payload only moves on i_ld
  always_comb begin
    v_d = i_clr ? 1'b0 : i_v;
    d_d = i_ld ? i_d : d_q;
    c_d = i_ld ? i_c : c_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= 1'b0;
      d_q <= '0;
      c_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      c_q <= c_d;
    end
  end

  assign o_v = v_q;
  assign o_d = d_q;
  assign o_c = c_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module : pipe_stage_skid
// Brief  : Valid/ready pipeline stage with 2-entry skid buffer, flush and
//          bubble-gated control. Optional stall counter: PIPE_STAGE_STALL_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic flush,
  pipe_stage_skid_if.slave bus
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CTRL_W-1:0] main_c, skid_c;

  logic              in_fire, out_fire;
  logic              main_ld, main_from_skid, skid_ld;
  logic              main_v_nx, skid_v_nx;
  logic [DATA_W-1:0] main_d_in;
  logic [CTRL_W-1:0] main_c_in;
  skid_state_e       state;

  assign state    = skid_state_e'({main_v, skid_v});
  assign in_fire  = bus.i_valid & ~skid_v;
  assign out_fire = main_v & bus.i_ready;

  always_comb begin
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    main_v_nx      = main_v;
    skid_v_nx      = skid_v;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_ld   = 1'b1;
          main_v_nx = 1'b1;
        end
      end
      ST_HALF: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          skid_ld   = 1'b1;
          skid_v_nx = 1'b1;
        end else if (out_fire) begin
          main_v_nx = 1'b0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          skid_v_nx      = 1'b0;
        end
      end
      default: begin
        // {main_v, skid_v} = 01 is unreachable; fall back to empty
        main_v_nx = 1'b0;
        skid_v_nx = 1'b0;
      end
    endcase
  end

  assign main_d_in = main_from_skid ? skid_d : bus.i_data;
  assign main_c_in = main_from_skid ? skid_c : bus.i_ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_ld  (main_ld & ~flush),
    .i_v   (main_v_nx),
    .i_d   (main_d_in),
    .i_c   (main_c_in),
    .o_v   (main_v),
    .o_d   (main_d),
    .o_c   (main_c)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_ld  (skid_ld & ~flush),
    .i_v   (skid_v_nx),
    .i_d   (bus.i_data),
    .i_c   (bus.i_ctrl),
    .o_v   (skid_v),
    .o_d   (skid_d),
    .o_c   (skid_c)
  );

  assign bus.o_valid = main_v;
  assign bus.o_data  = main_d;
  assign bus.o_ctrl  = main_v ? main_c : '0;
  assign bus.o_ready = ~skid_v;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; only reset clears it so flushes do not hide stall history
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v && !bus.i_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module : tb_pipe_stage_skid
// Brief  : Directed self-checking bench for pipe_stage_skid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  logic flush;

  int n_vec;
  int n_err;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_ctrl  = c;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    flush = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b1, 101'h5, 8'h00);

    // Reset held for two edges while a beat is offered
    tick();
    tick();
    chk("rst_valid", {127'b0, bus.o_valid}, 128'd0);
    chk("rst_ready", {127'b0, bus.o_ready}, 128'd1);
    chk("rst_data",  {27'b0, bus.o_data},   128'd0);
    chk("rst_ctrl",  {120'b0, bus.o_ctrl},  128'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("rst_cnt",   {124'b0, stall_cnt},   128'd0);
`endif
    reset = 1'b1;
    tick();
    chk("post_rst_valid", {127'b0, bus.o_valid}, 128'd1);
    chk("post_rst_data",  {27'b0, bus.o_data},   128'h5);
    drive(1'b0, '0, '0);
    tick();
    chk("post_rst_drain", {127'b0, bus.o_valid}, 128'd0);

    // Back-to-back streaming with downstream always ready
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DATA_W'(k), 8'h00);
      tick();
      chk("stream_valid", {127'b0, bus.o_valid}, 128'd1);
      chk("stream_data",  {27'b0, bus.o_data},   128'(k));
      chk("stream_ready", {127'b0, bus.o_ready}, 128'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_end", {127'b0, bus.o_valid}, 128'd0);

    // Back-pressure: A in main, B in skid, C refused
    bus.i_ready = 1'b0;
    drive(1'b1, 101'hA, 8'h00);
    tick();
    chk("bp_a_data",  {27'b0, bus.o_data},   128'hA);
    chk("bp_a_ready", {127'b0, bus.o_ready}, 128'd1);
    drive(1'b1, 101'hB, 8'h00);
    tick();
    chk("bp_full_ready", {127'b0, bus.o_ready}, 128'd0);
    chk("bp_full_data",  {27'b0, bus.o_data},   128'hA);
    drive(1'b1, 101'hC, 8'h00);
    tick();
    chk("bp_c_refused", {127'b0, bus.o_ready}, 128'd0);
    chk("bp_hold_a",    {27'b0, bus.o_data},   128'hA);
    bus.i_ready = 1'b1;
    tick();
    chk("bp_out_b",   {27'b0, bus.o_data},   128'hB);
    chk("bp_b_ready", {127'b0, bus.o_ready}, 128'd1);
    tick();
    chk("bp_out_c",   {27'b0, bus.o_data},   128'hC);
    chk("bp_c_valid", {127'b0, bus.o_valid}, 128'd1);
    drive(1'b0, '0, '0);
    tick();
    chk("bp_drained", {127'b0, bus.o_valid}, 128'd0);

    // Flush while FULL, with a new beat offered in the same cycle
    bus.i_ready = 1'b0;
    drive(1'b1, 101'h1A, 8'h03);
    tick();
    drive(1'b1, 101'h1B, 8'h03);
    tick();
    chk("fl_full", {127'b0, bus.o_ready}, 128'd0);
    flush = 1'b1;
    drive(1'b1, 101'h1C, 8'h03);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_valid", {127'b0, bus.o_valid}, 128'd0);
    chk("fl_ctrl",  {120'b0, bus.o_ctrl},  128'd0);
    chk("fl_ready", {127'b0, bus.o_ready}, 128'd1);
    bus.i_ready = 1'b1;
    tick();
    chk("fl_no_c", {127'b0, bus.o_valid}, 128'd0);

    // Bubble gating of control
    drive(1'b0, 101'h66, 8'hFF);
    tick();
    chk("bub_ctrl",  {120'b0, bus.o_ctrl},  128'd0);
    chk("bub_valid", {127'b0, bus.o_valid}, 128'd0);
    drive(1'b1, 101'h77, 8'h03);
    tick();
    chk("beat_ctrl", {120'b0, bus.o_ctrl}, 128'h03);
    chk("beat_data", {27'b0, bus.o_data},  128'h77);
    drive(1'b0, 101'h66, 8'hFF);
    tick();
    chk("bub_after", {120'b0, bus.o_ctrl}, 128'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter saturation, immunity to flush, clear on reset
    bus.i_ready = 1'b0;
    drive(1'b1, 101'h99, 8'h01);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 0; k < 20; k++) tick();
    chk("cnt_valid", {127'b0, bus.o_valid}, 128'd1);
    chk("cnt_sat",   {124'b0, stall_cnt},   128'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cnt_flush", {124'b0, stall_cnt}, 128'd15);
    reset = 1'b0;
    tick();
    chk("cnt_reset", {124'b0, stall_cnt}, 128'd0);
    reset = 1'b1;
    bus.i_ready = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
